// File: rtl/spi_host_ctrl.sv
// SPI initiator for the PSEC5 link: shifts wr_len bytes out LSB first, then captures rd_len readout bits.
// Define SPI_HOST_CSN_EN to add an active-low csn output with one setup and one hold period around the bits.
`timescale 1ns/1ps
module spi_host_ctrl #(
    parameter int CLK_DIV   = 1,
    parameter int MAX_BYTES = 4,
    parameter int RD_MAX    = 64
) (
    input  logic                   iclk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [3:0]             wr_len,
    input  logic [8*MAX_BYTES-1:0] wr_data,
    input  logic [6:0]             rd_len,
    output logic                   busy,
    output logic                   done,
    output logic [RD_MAX-1:0]      rd_data,
    output logic                   sclk,
    output logic                   serial_in,
    input  logic                   serial_out
`ifdef SPI_HOST_CSN_EN
    ,
    output logic                   csn
`endif
);
    localparam int WB   = 8 * MAX_BYTES;
    localparam int WI_W = (WB > 1) ? $clog2(WB) : 1;
    localparam int RI_W = (RD_MAX > 1) ? $clog2(RD_MAX) : 1;
    localparam int WL_W = $clog2(MAX_BYTES + 1);
    localparam int RL_W = $clog2(RD_MAX + 1);
    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_LO, WR_HI, RD_LO, RD_HI, FIN, CS_SETUP, CS_HOLD
    } state_t;

`ifdef SPI_HOST_CSN_EN
    localparam state_t TAIL_ST = CS_HOLD;
`else
    localparam state_t TAIL_ST = FIN;
`endif

    state_t          state_reg;
    logic [HC_W-1:0] hc_reg;
    logic [WI_W-1:0] wbit_reg;
    logic [RI_W-1:0] rbit_reg;
    logic [WB-1:0]   wr_buf_reg;
    logic [WL_W-1:0] wr_bytes_reg;
    logic [RL_W-1:0] rd_bits_reg;

    logic [WL_W-1:0] wr_len_c;
    logic [RL_W-1:0] rd_len_c;
    logic            hc_end;
    logic            wbit_last;
    logic            rbit_last;
    logic [WI_W-1:0] wbit_nxt;
    state_t          after_wr;

    // Requests beyond the configured limits are clamped rather than rejected.
    assign wr_len_c  = (wr_len > 4'(MAX_BYTES)) ? WL_W'(MAX_BYTES) : WL_W'(wr_len);
    assign rd_len_c  = (rd_len > 7'(RD_MAX)) ? RL_W'(RD_MAX) : RL_W'(rd_len);
    assign hc_end    = (hc_reg == HC_W'(CLK_DIV - 1));
    assign wbit_last = (wbit_reg == WI_W'({wr_bytes_reg - WL_W'(1), 3'b111}));
    assign rbit_last = (rbit_reg == RI_W'(rd_bits_reg - RL_W'(1)));
    assign wbit_nxt  = wbit_reg + WI_W'(1);
    assign after_wr  = (rd_bits_reg != '0) ? RD_LO : TAIL_ST;

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            hc_reg       <= '0;
            wbit_reg     <= '0;
            rbit_reg     <= '0;
            wr_buf_reg   <= '0;
            wr_bytes_reg <= '0;
            rd_bits_reg  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_data      <= '0;
            sclk         <= 1'b0;
            serial_in    <= 1'b0;
`ifdef SPI_HOST_CSN_EN
            csn          <= 1'b1;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        wr_buf_reg   <= wr_data;
                        wr_bytes_reg <= wr_len_c;
                        rd_bits_reg  <= rd_len_c;
                        rd_data      <= '0;
                        busy         <= 1'b1;
                        hc_reg       <= '0;
                        wbit_reg     <= '0;
                        rbit_reg     <= '0;
`ifdef SPI_HOST_CSN_EN
                        csn          <= 1'b0;
                        state_reg    <= CS_SETUP;
`else
                        if (wr_len_c != '0) begin
                            state_reg <= WR_LO;
                            serial_in <= wr_data[0];
                        end else if (rd_len_c != '0) begin
                            state_reg <= RD_LO;
                        end else begin
                            state_reg <= FIN;
                        end
`endif
                    end
                end
                CS_SETUP: begin
                    if (hc_end) begin
                        hc_reg <= '0;
                        if (wr_bytes_reg != '0) begin
                            state_reg <= WR_LO;
                            serial_in <= wr_buf_reg[0];
                        end else begin
                            state_reg <= after_wr;
                        end
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                WR_LO: begin
                    if (hc_end) begin
                        hc_reg    <= '0;
                        sclk      <= 1'b1;
                        state_reg <= WR_HI;
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                WR_HI: begin
                    if (hc_end) begin
                        hc_reg <= '0;
                        sclk   <= 1'b0;
                        // Next data bit launches on the same edge sclk falls.
                        if (wbit_last) begin
                            serial_in <= 1'b0;
                            state_reg <= after_wr;
                        end else begin
                            wbit_reg  <= wbit_nxt;
                            serial_in <= wr_buf_reg[wbit_nxt];
                            state_reg <= WR_LO;
                        end
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                RD_LO: begin
                    if (hc_end) begin
                        hc_reg            <= '0;
                        sclk              <= 1'b1;
                        rd_data[rbit_reg] <= serial_out;
                        state_reg         <= RD_HI;
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                RD_HI: begin
                    if (hc_end) begin
                        hc_reg <= '0;
                        sclk   <= 1'b0;
                        if (rbit_last) begin
                            state_reg <= TAIL_ST;
                        end else begin
                            rbit_reg  <= rbit_reg + RI_W'(1);
                            state_reg <= RD_LO;
                        end
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (hc_end) begin
                        hc_reg    <= '0;
                        state_reg <= FIN;
                    end else begin
                        hc_reg <= hc_reg + HC_W'(1);
                    end
                end
                FIN: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
`ifdef SPI_HOST_CSN_EN
                    csn       <= 1'b1;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl: one instance at CLK_DIV=1 and one at CLK_DIV=2 share the payload inputs.
`timescale 1ns/1ps
module tb_spi_host_ctrl;
`ifdef SPI_HOST_CSN_EN
    localparam int EX0 = 2;
    localparam int EX1 = 4;
`else
    localparam int EX0 = 0;
    localparam int EX1 = 0;
`endif

    logic        iclk = 1'b0;
    logic        rstn;
    logic        start_s [2];
    logic [3:0]  wr_len;
    logic [31:0] wr_data;
    logic [6:0]  rd_len;
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        sclk_s  [2];
    logic        sin_s   [2];
    logic        sout_s  [2];
    logic [63:0] rdd_s   [2];
`ifdef SPI_HOST_CSN_EN
    logic        csn_s   [2];
`endif

    int          tests = 0;
    int          fails = 0;
    int          rise    [2];
    int          wbits   [2];
    logic [31:0] sin_cap [2];
    logic [63:0] pat_s   [2];

    always #5 iclk = ~iclk;

    spi_host_ctrl #(.CLK_DIV(1), .MAX_BYTES(4), .RD_MAX(64)) u_div1 (
        .iclk(iclk), .rstn(rstn), .start(start_s[0]), .wr_len(wr_len), .wr_data(wr_data),
        .rd_len(rd_len), .busy(busy_s[0]), .done(done_s[0]), .rd_data(rdd_s[0]),
        .sclk(sclk_s[0]), .serial_in(sin_s[0]), .serial_out(sout_s[0])
`ifdef SPI_HOST_CSN_EN
        , .csn(csn_s[0])
`endif
    );

    spi_host_ctrl #(.CLK_DIV(2), .MAX_BYTES(4), .RD_MAX(64)) u_div2 (
        .iclk(iclk), .rstn(rstn), .start(start_s[1]), .wr_len(wr_len), .wr_data(wr_data),
        .rd_len(rd_len), .busy(busy_s[1]), .done(done_s[1]), .rd_data(rdd_s[1]),
        .sclk(sclk_s[1]), .serial_in(sin_s[1]), .serial_out(sout_s[1])
`ifdef SPI_HOST_CSN_EN
        , .csn(csn_s[1])
`endif
    );

    // Peripheral model: records MOSI at each sclk rise, presents readout bit k after the write bits.
    always @(posedge sclk_s[0]) begin
        if (rise[0] < 32) sin_cap[0][rise[0]] = sin_s[0];
        rise[0] = rise[0] + 1;
    end
    always @(posedge sclk_s[1]) begin
        if (rise[1] < 32) sin_cap[1][rise[1]] = sin_s[1];
        rise[1] = rise[1] + 1;
    end
    always_comb begin
        sout_s[0] = 1'b0;
        sout_s[1] = 1'b0;
        if (rise[0] >= wbits[0] && rise[0] - wbits[0] < 64) sout_s[0] = pat_s[0][rise[0] - wbits[0]];
        if (rise[1] >= wbits[1] && rise[1] - wbits[1] < 64) sout_s[1] = pat_s[1][rise[1] - wbits[1]];
    end

    task automatic clear_mon(input int u, input int nbytes, input logic [63:0] p);
        rise[u]    = 0;
        sin_cap[u] = '0;
        wbits[u]   = 8 * nbytes;
        pat_s[u]   = p;
    endtask

    task automatic run_txn(input int u, input int budget, output int lat, output int bcyc);
        lat  = -1;
        bcyc = 0;
        @(negedge iclk);
        start_s[u] = 1'b1;
        @(posedge iclk);
        #1 start_s[u] = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (done_s[u]) begin
                lat = n;
                break;
            end
            if (busy_s[u]) bcyc++;
            @(posedge iclk);
            #1;
        end
        repeat (3) @(posedge iclk);
        #1;
        $display("[TB] txn u%0d wr_len=%0d rd_len=%0d lat=%0d sclk_rises=%0d mosi=%08h rd_data=%016h",
                 u, wr_len, rd_len, lat, rise[u], sin_cap[u], rdd_s[u]);
    endtask

    task automatic test_reset();
        @(negedge iclk);
        tests++; if (busy_s[0] !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_s[0]); end
        tests++; if (done_s[0] !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done_s[0]); end
        tests++; if (sclk_s[0] !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b expected 0", sclk_s[0]); end
        tests++; if (sin_s[0] !== 1'b0) begin fails++; $display("FAIL reset_serial_in: got %b expected 0", sin_s[0]); end
        tests++; if (rdd_s[1] !== 64'h0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rdd_s[1]); end
`ifdef SPI_HOST_CSN_EN
        tests++; if (csn_s[0] !== 1'b1) begin fails++; $display("FAIL reset_csn: got %b expected 1", csn_s[0]); end
`endif
        rstn = 1'b1;
        repeat (2) @(posedge iclk);
        #1;
        tests++; if (busy_s[1] !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b expected 0", busy_s[1]); end
        $display("[TB] txn reset released");
    endtask

    task automatic test_write_only();
        int lat, bc;
        wr_len = 4'd1; wr_data = 32'h0000_0050; rd_len = 7'd0;
        clear_mon(0, 1, 64'h0);
        run_txn(0, 100, lat, bc);
        tests++; if (lat !== 17 + EX0) begin fails++; $display("FAIL wo_latency: got %0d expected %0d", lat, 17 + EX0); end
        tests++; if (rise[0] !== 8) begin fails++; $display("FAIL wo_sclk_pulses: got %0d expected 8", rise[0]); end
        tests++; if (sin_cap[0][7:0] !== 8'h50) begin fails++; $display("FAIL wo_mosi: got %h expected 50", sin_cap[0][7:0]); end
        tests++; if (rdd_s[0] !== 64'h0) begin fails++; $display("FAIL wo_rd_data: got %h expected 0", rdd_s[0]); end
        tests++; if (busy_s[0] !== 1'b0) begin fails++; $display("FAIL wo_busy_after: got %b expected 0", busy_s[0]); end
    endtask

    task automatic test_write_read();
        int lat, bc;
        wr_len = 4'd2; wr_data = 32'h0000_A5C3; rd_len = 7'd10;
        clear_mon(1, 2, 64'hFFFF_FFFF_FFFF_FEB5);
        run_txn(1, 300, lat, bc);
        tests++; if (lat !== 105 + EX1) begin fails++; $display("FAIL wr_latency: got %0d expected %0d", lat, 105 + EX1); end
        tests++; if (rise[1] !== 26) begin fails++; $display("FAIL wr_sclk_pulses: got %0d expected 26", rise[1]); end
        tests++; if (sin_cap[1][15:0] !== 16'hA5C3) begin fails++; $display("FAIL wr_mosi: got %h expected a5c3", sin_cap[1][15:0]); end
        tests++; if (rdd_s[1] !== 64'h2B5) begin fails++; $display("FAIL wr_rd_data: got %h expected 2b5", rdd_s[1]); end
    endtask

    task automatic test_zero_len();
        int lat, bc;
        wr_len = 4'd0; wr_data = 32'hFFFF_FFFF; rd_len = 7'd0;
        clear_mon(0, 0, 64'h0);
        run_txn(0, 50, lat, bc);
        tests++; if (lat !== 1 + EX0) begin fails++; $display("FAIL zero_latency: got %0d expected %0d", lat, 1 + EX0); end
        tests++; if (bc !== 1 + EX0) begin fails++; $display("FAIL zero_busy_cycles: got %0d expected %0d", bc, 1 + EX0); end
        tests++; if (rise[0] !== 0) begin fails++; $display("FAIL zero_sclk_pulses: got %0d expected 0", rise[0]); end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        int ndone = 0;
        wr_len = 4'd1; wr_data = 32'h0000_0050; rd_len = 7'd0;
        clear_mon(0, 1, 64'h0);
        @(negedge iclk);
        start_s[0] = 1'b1;
        @(posedge iclk);
        #1;
        wr_data = 32'hFFFF_FFFF;
        wr_len  = 4'd4;
        rd_len  = 7'd64;
        for (int n = 0; n < 60; n++) begin
            if (done_s[0]) begin
                ndone++;
                if (lat < 0) lat = n;
                start_s[0] = 1'b0;
            end
            @(posedge iclk);
            #1;
        end
        start_s[0] = 1'b0;
        $display("[TB] txn start-spam lat=%0d dones=%0d sclk_rises=%0d mosi=%02h", lat, ndone, rise[0], sin_cap[0][7:0]);
        tests++; if (ndone !== 1) begin fails++; $display("FAIL spam_done_count: got %0d expected 1", ndone); end
        tests++; if (lat !== 17 + EX0) begin fails++; $display("FAIL spam_latency: got %0d expected %0d", lat, 17 + EX0); end
        tests++; if (rise[0] !== 8) begin fails++; $display("FAIL spam_sclk_pulses: got %0d expected 8", rise[0]); end
        tests++; if (sin_cap[0][7:0] !== 8'h50) begin fails++; $display("FAIL spam_mosi: got %h expected 50", sin_cap[0][7:0]); end
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        int ndone = 0;
        bit reached = 0;
        wr_len = 4'd1; wr_data = 32'h0000_0050; rd_len = 7'd0;
        clear_mon(0, 1, 64'h0);
        @(negedge iclk);
        start_s[0] = 1'b1;
        @(posedge iclk);
        #1 start_s[0] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (rise[0] >= 5) begin
                reached = 1;
                break;
            end
            @(posedge iclk);
            #1;
        end
        tests++; if (reached !== 1'b1) begin fails++; $display("FAIL mid_reach_bit5: got %0d rises expected 5", rise[0]); end
        #2 rstn = 1'b0;
        #1;
        $display("[TB] txn reset during write bit 5: sclk=%b mosi=%b busy=%b done=%b", sclk_s[0], sin_s[0], busy_s[0], done_s[0]);
        tests++; if (sclk_s[0] !== 1'b0) begin fails++; $display("FAIL mid_sclk: got %b expected 0", sclk_s[0]); end
        tests++; if (sin_s[0] !== 1'b0) begin fails++; $display("FAIL mid_serial_in: got %b expected 0", sin_s[0]); end
        tests++; if (busy_s[0] !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", busy_s[0]); end
        tests++; if (done_s[0] !== 1'b0) begin fails++; $display("FAIL mid_done: got %b expected 0", done_s[0]); end
        @(negedge iclk);
        rstn = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge iclk);
            #1;
            if (done_s[0]) ndone++;
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL mid_no_done: got %0d expected 0", ndone); end
        clear_mon(0, 1, 64'h0);
        run_txn(0, 100, lat, bc);
        tests++; if (lat !== 17 + EX0) begin fails++; $display("FAIL mid_rerun_latency: got %0d expected %0d", lat, 17 + EX0); end
        tests++; if (sin_cap[0][7:0] !== 8'h50) begin fails++; $display("FAIL mid_rerun_mosi: got %h expected 50", sin_cap[0][7:0]); end
    endtask

    task automatic test_clamp();
        int lat, bc;
        wr_len = 4'd7; wr_data = 32'hDEAD_BEEF; rd_len = 7'd100;
        clear_mon(0, 4, 64'h0123_4567_89AB_CDEF);
        run_txn(0, 400, lat, bc);
        tests++; if (lat !== 193 + EX0) begin fails++; $display("FAIL clamp_latency: got %0d expected %0d", lat, 193 + EX0); end
        tests++; if (rise[0] !== 96) begin fails++; $display("FAIL clamp_sclk_pulses: got %0d expected 96", rise[0]); end
        tests++; if (sin_cap[0] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL clamp_mosi: got %h expected deadbeef", sin_cap[0]); end
        tests++; if (rdd_s[0] !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL clamp_rd_data: got %h expected 0123456789abcdef", rdd_s[0]); end
    endtask

    initial begin
        rstn = 1'b1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        wr_len = 4'd0; wr_data = 32'h0; rd_len = 7'd0;
        clear_mon(0, 0, 64'h0);
        clear_mon(1, 0, 64'h0);
        #3 rstn = 1'b0;
        repeat (3) @(posedge iclk);
        test_reset();
        test_write_only();
        test_write_read();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_host_ctrl.md
Name: spi_host_ctrl

Overview:
- SPI initiator on the controller side of the PSEC5 digital SPI link. Drives `sclk` and `serial_in` into the SPI peripheral and captures the muxed `serial_out` returning from it.
- Each transaction shifts a configurable number of command/config bytes out, LSB first. It then optionally clocks in a readout stream, for example channel counter bits via `load_cnt_ser`.
- Sits in the FPGA/bench-side controller. Replaces hand-toggled `serial_in` stimulus.

Parameters:
- CLK_DIV, 1, `iclk` cycles per `sclk` half-period (>=1).
- MAX_BYTES, 4, maximum write bytes per transaction.
- RD_MAX, 64, maximum readout bits per transaction.

Ports:
- iclk  input  1  system clock, all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  transaction request, sampled when idle
- wr_len  input  4  number of bytes to write (0..MAX_BYTES)
- wr_data  input  8*MAX_BYTES  write payload; byte 0 = wr_data[7:0], sent first
- rd_len  input  7  readout bits to capture after write (0..RD_MAX)
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle completion pulse
- rd_data  output  RD_MAX  captured readout; bit k at rd_data[k]
- sclk  output  1  SPI clock, idle low
- serial_in  output  1  MOSI to peripheral
- serial_out  input  1  MISO from mux

Behaviour:
- Reset values: busy=0, done=0, rd_data=0, sclk=0, serial_in=0, FSM=IDLE, counters=0.
- Reset mid-transaction aborts immediately. sclk and serial_in drop low asynchronously. No done pulse.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, FIN.
- IDLE:
  - On start=1, latch wr_data, wr_len and rd_len, each clamped to MAX_BYTES or RD_MAX.
  - Clear rd_data and set busy=1.
  - Next state: WR_LO if wr_len>0, else RD_LO if rd_len>0, else FIN.
- start while busy is ignored. Latched inputs are stable for the whole transaction.
- Bit timing: each bit is one low phase (sclk=0) then one high phase (sclk=1), each CLK_DIV `iclk` cycles. A half-period counter counts 0..CLK_DIV-1.
- WR_LO:
  - serial_in updates on entry (coincident with the sclk falling edge).
  - Bit order: byte 0 bit 0 first, up to byte wr_len-1 bit 7.
- WR_HI:
  - sclk=1; the peripheral samples on the rising edge.
  - After the last write bit, go to RD_LO if rd_len>0, else FIN.
- RD_LO: sclk=0; serial_in held 0.
- RD_HI:
  - sclk=1; serial_out is registered into rd_data[rd_cnt] in the `iclk` cycle sclk rises.
  - After bit rd_len-1, go to FIN.
- FIN:
  - sclk=0, done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE.
- Latency: done asserts 2*CLK_DIV*(8*wr_len+rd_len)+1 `iclk` cycles after the start-accept edge.
- Zero-length case (wr_len=0, rd_len=0): done is one cycle after accept; no sclk pulse.
- Unfilled rd_data bits (index >= rd_len) stay 0.
- sclk is a registered output; there are no glitches between bits, and phases are continuous across the write/read boundary.

Optional Feature:
- Macro: SPI_HOST_CSN_EN.
- When defined, add output `csn` (1 bit, reset 1).
  - csn falls on the start-accept edge.
  - One extra low-phase setup period (CLK_DIV cycles, sclk=0) precedes the first bit.
  - One extra hold period follows the last high phase before FIN.
  - csn rises together with the done pulse.
  - Latency grows by 2*CLK_DIV.
- When undefined: no csn port and no setup/hold periods.

Test Plan:
- CLK_DIV=1, wr_len=1, wr_data[7:0]=0x50, rd_len=0 -> serial_in at 8 sclk rises = 0,0,0,0,1,0,1,0; exactly 8 sclk pulses; done 17 cycles after accept; rd_data=0.
- CLK_DIV=2, wr_len=2, wr_data[15:0]=0xA5C3, rd_len=10, serial_out driven with pattern 0x2B5 LSB first -> 16 write bits C3 then A5 LSB first; rd_data[9:0]=0x2B5, rd_data[63:10]=0; done at 105 cycles.
- wr_len=0, rd_len=0 -> done one cycle after start; sclk stays 0; busy high for exactly one cycle.
- start pulsed every cycle during a transaction -> only the first is accepted; exactly one done; sclk pulse count matches the first request.
- rstn asserted low during the 5th write bit -> sclk, serial_in, busy and done go 0 immediately; after release, a new 0x50 transaction completes correctly.
- wr_len=7, rd_len=100 with defaults -> clamped to 4 bytes / 64 bits; 96 sclk pulses; done at 193 cycles.
